// File: rtl/usart_cmd_parser.sv
// Purpose: parses CMD/LEN/payload/CSUM byte frames into DDS control registers.
// Latency: registers, upd and done/err update on the cycle after the CSUM byte is taken.
// Backpressure: none; bytes are consumed whenever rx_valid is high.
module usart_cmd_parser #(
    parameter int FREQ_W      = 24,
    parameter int AMP_W       = 12,
    parameter int PHASE_W     = 12,
    parameter int MAX_BYTES   = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [FREQ_W-1:0]  freq_word,
    output logic [AMP_W-1:0]   amp_word,
    output logic [PHASE_W-1:0] phase_word,
    output logic [1:0]         wave_sel,
    output logic [3:0]         upd,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int ACC_W = MAX_BYTES * 8;
    localparam int TC_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] CMD_F = 8'h46;
    localparam logic [7:0] CMD_M = 8'h4D;
    localparam logic [7:0] CMD_P = 8'h50;
    localparam logic [7:0] CMD_W = 8'h57;

    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TO   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cmd;
    logic [7:0]       csum;
    logic [3:0]       left;
    logic [ACC_W-1:0] acc;
    logic [TC_W-1:0]  tcnt;

    logic             is_cmd;
    logic             len_bad;
    logic             timeout_hit;
    logic             take_frame;
    logic             raise_err;
    logic [1:0]       err_code_nxt;

    assign is_cmd  = (rx_data == CMD_F) || (rx_data == CMD_M) ||
                     (rx_data == CMD_P) || (rx_data == CMD_W);
    assign len_bad = (rx_data == 8'd0) || (rx_data > 8'(MAX_BYTES));

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit = (state != S_IDLE) && !rx_valid &&
                         (tcnt == TC_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        take_frame   = 1'b0;
        raise_err    = 1'b0;
        err_code_nxt = err_code;
        if (timeout_hit) begin
            state_nxt    = S_IDLE;
            raise_err    = 1'b1;
            err_code_nxt = ERR_TO;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (is_cmd) begin
                        state_nxt = S_LEN;
                    end
                end
                S_LEN: begin
                    if (len_bad) begin
                        state_nxt    = S_IDLE;
                        raise_err    = 1'b1;
                        err_code_nxt = ERR_LEN;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (left == 4'd1) begin
                        state_nxt = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_nxt = S_IDLE;
                    if (rx_data == csum) begin
                        take_frame = 1'b1;
                    end else begin
                        raise_err    = 1'b1;
                        err_code_nxt = ERR_CSUM;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd  <= 8'd0;
            csum <= 8'd0;
            left <= 4'd0;
            acc  <= '0;
            tcnt <= '0;
        end else begin
            if ((state == S_IDLE) || rx_valid || timeout_hit) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (rx_valid && !timeout_hit) begin
                case (state)
                    S_IDLE: begin
                        if (is_cmd) begin
                            cmd  <= rx_data;
                            csum <= rx_data;
                        end
                    end
                    S_LEN: begin
                        csum <= csum ^ rx_data;
                        left <= rx_data[3:0];
                        acc  <= '0;
                    end
                    S_DATA: begin
                        csum <= csum ^ rx_data;
                        left <= left - 4'd1;
                        acc  <= (acc << 8) | ACC_W'(rx_data);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Accumulator is truncated or zero-extended to each target width.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_word  <= '0;
            amp_word   <= '0;
            phase_word <= '0;
            wave_sel   <= 2'd0;
            upd        <= 4'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            upd  <= 4'd0;
            done <= 1'b0;
            err  <= 1'b0;
            if (take_frame) begin
                done <= 1'b1;
                case (cmd)
                    CMD_F: begin
                        freq_word <= FREQ_W'(acc);
                        upd       <= 4'b0001;
                    end
                    CMD_M: begin
                        amp_word <= AMP_W'(acc);
                        upd      <= 4'b0010;
                    end
                    CMD_P: begin
                        phase_word <= PHASE_W'(acc);
                        upd        <= 4'b0100;
                    end
                    default: begin
                        wave_sel <= acc[1:0];
                        upd      <= 4'b1000;
                    end
                endcase
            end
            if (raise_err) begin
                err      <= 1'b1;
                err_code <= err_code_nxt;
            end
        end
    end

endmodule
